xy2_frame_scheduler: RTL and testbench

Paces 16-bit galvo position words into the XY2-100 serial sender at a fixed frame rate.
- Buffers incoming points in a small FIFO.
- Issues exactly one sender Start pulse per frame tick, gated on the sender's done flag.
- On FIFO underrun, repeats the last point so the galvo holds position.
- Sits between the scan-pattern generator upstream and xy2_100_send downstream; reports underrun, overrun and timeout status to the control registers.

---
 rtl/xy2_pkg.sv | 16 +
 rtl/xy2_point_fifo.sv | 57 +++++
 rtl/xy2_frame_scheduler.sv | 134 +++++++++++++
 tb/tb_xy2_frame_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xy2_pkg.sv
// Shared state encoding and constants for the XY2-100 frame scheduler.
package xy2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    START,
    WAIT_LOW,
    WAIT_DONE
  } xy2_state_e;

  localparam logic [15:0] XY2_MIDSCALE   = 16'h8000;
  localparam int          XY2_FRAME_CLKS = 400;

endpackage

// File: rtl/xy2_point_fifo.sv
// Synchronous point FIFO with flush; head word visible combinationally, level registered.
// Push while full is accepted only when a pop happens in the same cycle; flush wins over both.
module xy2_point_fifo
  import xy2_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (!Rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge Clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/xy2_frame_scheduler.sv
// Paces buffered galvo points into the XY2-100 sender: one Start per frame tick, repeat last point on underrun.
// Tick to tx_start is 2 clocks; pt_ready drops when the FIFO is full unless a pop frees a slot that cycle.
module xy2_frame_scheduler
  import xy2_pkg::*;
#(
  parameter int FRAME_PERIOD = XY2_FRAME_CLKS + 20,
  parameter int FIFO_DEPTH   = 16,
  parameter int TIMEOUT      = 1023,
  parameter int CNT_W        = 16
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          pt_valid,
  input  logic [15:0]                   pt_data,
  output logic                          pt_ready,
  output logic [15:0]                   tx_data,
  output logic                          tx_start,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              underrun_cnt,
  output logic [CNT_W-1:0]              overrun_cnt,
  output logic                          timeout_err
);

  localparam int                TICK_W    = $clog2(FRAME_PERIOD);
  localparam int                TO_W      = $clog2(TIMEOUT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  xy2_state_e        state;
  xy2_state_e        state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              tick;
  logic              waiting;
  logic              timeout_hit;
  logic              overrun_inc;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [15:0]       fifo_head;

  xy2_point_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .flush    (flush),
    .push     (fifo_push),
    .push_dat (pt_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign fifo_pop    = (state == ISSUE) && !fifo_empty;
  assign pt_ready    = !fifo_full || fifo_pop;
  assign fifo_push   = pt_valid && pt_ready;

  assign tick        = enable && (tick_cnt == TICK_LAST);
  assign waiting     = (state == WAIT_LOW) || (state == WAIT_DONE);
  assign timeout_hit = waiting && (to_cnt == TO_LAST);
  // Any tick that cannot launch a frame is a missed frame, including ticks landing mid-transfer.
  assign overrun_inc = tick && (state != IDLE) && !((state == WAIT_TICK) && tx_done);

  assign tx_start    = (state == START);
  assign busy        = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (!Rst_n || !enable) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n || !waiting) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // A timed-out sender stays parked until reset.
      IDLE:      if (enable && !timeout_err) state_nxt = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable)               state_nxt = IDLE;
        else if (tick && tx_done)  state_nxt = ISSUE;
      end
      ISSUE:     state_nxt = START;
      START:     state_nxt = WAIT_LOW;
      WAIT_LOW:  if (!tx_done) state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done)  state_nxt = enable ? WAIT_TICK : IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = IDLE;
  end

  // tx_data doubles as the last point replayed on underrun.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state        <= IDLE;
      tx_data      <= XY2_MIDSCALE;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ISSUE) begin
        if (!fifo_empty) begin
          tx_data <= fifo_head;
        end else if (underrun_cnt != {CNT_W{1'b1}}) begin
          underrun_cnt <= underrun_cnt + 1'b1;
        end
      end
      if (overrun_inc && (overrun_cnt != {CNT_W{1'b1}})) overrun_cnt <= overrun_cnt + 1'b1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xy2_frame_scheduler.sv
// Directed bench: frame pacing, underrun replay, overrun, timeout, FIFO full/flush, enable drop.
module tb_xy2_frame_scheduler;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        enable, flush, pt_valid;
  logic [15:0] pt_data;
  logic        pt_ready, tx_start, busy, timeout_err;
  logic [15:0] tx_data, underrun_cnt, overrun_cnt;
  logic [4:0]  fifo_level;
  logic        tx_done = 1'b1;

  logic        f_enable;
  logic        f_pt_ready, f_tx_start, f_busy, f_err;
  logic [15:0] f_tx_data, f_underrun, f_overrun;
  logic [4:0]  f_level;
  logic        f_tx_done = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int snd_cnt = 0;
  int f_snd_cnt = 0;
  bit snd_hang = 1'b0;
  int bad_start = 0;
  int dbl_start = 0;
  bit prev_start = 1'b0;
  int f_starts = 0;
  int f_bad = 0;
  int f_last = 0;
  int f_prev = 0;
  logic [15:0] start_data [$];
  int          start_time [$];
  int t0, base;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  xy2_frame_scheduler u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .enable(enable), .flush(flush),
    .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .busy(busy),
    .fifo_level(fifo_level), .underrun_cnt(underrun_cnt),
    .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  xy2_frame_scheduler #(.FRAME_PERIOD(300)) u_fast (
    .Clk(Clk), .Rst_n(Rst_n), .enable(f_enable), .flush(1'b0),
    .pt_valid(1'b0), .pt_data(16'h0000), .pt_ready(f_pt_ready),
    .tx_data(f_tx_data), .tx_start(f_tx_start), .tx_done(f_tx_done), .busy(f_busy),
    .fifo_level(f_level), .underrun_cnt(f_underrun),
    .overrun_cnt(f_overrun), .timeout_err(f_err)
  );

  // Sender models: done drops after Start and returns 400 clocks later.
  always @(posedge Clk) begin
    if (!Rst_n) begin
      tx_done <= 1'b1;
      snd_cnt <= 0;
    end else if (tx_start) begin
      tx_done <= 1'b0;
      snd_cnt <= 400;
    end else if (!tx_done && !snd_hang) begin
      if (snd_cnt <= 1) tx_done <= 1'b1;
      else              snd_cnt <= snd_cnt - 1;
    end
  end

  always @(posedge Clk) begin
    if (!Rst_n) begin
      f_tx_done <= 1'b1;
      f_snd_cnt <= 0;
    end else if (f_tx_start) begin
      f_tx_done <= 1'b0;
      f_snd_cnt <= 400;
    end else if (!f_tx_done) begin
      if (f_snd_cnt <= 1) f_tx_done <= 1'b1;
      else                f_snd_cnt <= f_snd_cnt - 1;
    end
  end

  always @(negedge Clk) begin
    prev_start <= tx_start;
    if (tx_start) begin
      start_data.push_back(tx_data);
      start_time.push_back(cyc);
      if (tx_done !== 1'b1) bad_start <= bad_start + 1;
      if (prev_start)       dbl_start <= dbl_start + 1;
    end
    if (f_tx_start) begin
      f_starts <= f_starts + 1;
      f_prev   <= f_last;
      f_last   <= cyc;
      if (f_tx_done !== 1'b1) f_bad <= f_bad + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (start_data.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(start_data.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    Rst_n = 1'b0; enable = 1'b0; f_enable = 1'b0; flush = 1'b0;
    pt_valid = 1'b0; pt_data = 16'h0000;
    step(3);
    check("rst_pt_ready", 32'(pt_ready), 1);
    check("rst_tx_data", 32'(tx_data), 32'h8000);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_underrun", 32'(underrun_cnt), 0);
    check("rst_overrun", 32'(overrun_cnt), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    Rst_n = 1'b1;
    step(1);

    // Three points then two underrun repeats of the last one.
    pt_valid = 1'b1;
    pt_data = 16'h1234; step(1);
    pt_data = 16'hABCD; step(1);
    pt_data = 16'h0001; step(1);
    pt_valid = 1'b0;
    check("t1_level", 32'(fifo_level), 3);
    enable = 1'b1; t0 = cyc; base = start_data.size();
    wait_starts(base + 5, 2300, "t1_starts");
    check("t1_latency", 32'(start_time[base] - t0), 421);
    check("t1_d0", 32'(start_data[base]), 32'h1234);
    check("t1_d1", 32'(start_data[base+1]), 32'hABCD);
    check("t1_d2", 32'(start_data[base+2]), 32'h0001);
    check("t1_d3", 32'(start_data[base+3]), 32'h0001);
    check("t1_d4", 32'(start_data[base+4]), 32'h0001);
    for (int i = 1; i < 5; i++)
      check("t1_period", 32'(start_time[base+i] - start_time[base+i-1]), 420);
    check("t1_underrun", 32'(underrun_cnt), 2);
    check("t1_overrun", 32'(overrun_cnt), 0);
    check("t1_level_empty", 32'(fifo_level), 0);

    // Reset in the middle of a frame.
    step(50);
    check("mid_busy", 32'(busy), 1);
    Rst_n = 1'b0; enable = 1'b0;
    step(1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_tx_data", 32'(tx_data), 32'h8000);
    check("mid_rst_underrun", 32'(underrun_cnt), 0);
    Rst_n = 1'b1;
    step(1);

    // Empty FIFO: first frame replays mid-scale.
    enable = 1'b1; t0 = cyc; base = start_data.size();
    wait_starts(base + 1, 600, "t2_start");
    check("t2_latency", 32'(start_time[base] - t0), 421);
    check("t2_data", 32'(start_data[base]), 32'h8000);
    check("t2_underrun", 32'(underrun_cnt), 1);

    // Drop enable mid-frame: frame completes, then idle for good.
    step(99);
    enable = 1'b0;
    step(250);
    check("t6_in_flight", 32'(busy), 1);
    wait_idle(400, "t6_idle");
    check("t6_idle_at", 32'(cyc - start_time[base]), 402);
    check("t6_done_high", 32'(tx_done), 1);
    step(2000);
    check("t6_no_start", 32'(start_data.size()), 32'(base + 1));
    check("t6_busy", 32'(busy), 0);
    check("t6_underrun", 32'(underrun_cnt), 1);

    // Sender never returns done: timeout, park in IDLE, hold tx_data.
    pt_valid = 1'b1; pt_data = 16'h5A5A; step(1); pt_valid = 1'b0;
    snd_hang = 1'b1; enable = 1'b1; base = start_data.size();
    wait_starts(base + 1, 600, "t4_start");
    check("t4_data", 32'(tx_data), 32'h5A5A);
    step(999);
    check("t4_err_early", 32'(timeout_err), 0);
    check("t4_busy_early", 32'(busy), 1);
    step(30);
    check("t4_err", 32'(timeout_err), 1);
    check("t4_busy", 32'(busy), 0);
    step(1500);
    check("t4_no_start", 32'(start_data.size()), 32'(base + 1));
    check("t4_busy_late", 32'(busy), 0);
    check("t4_data_hold", 32'(tx_data), 32'h5A5A);
    enable = 1'b0; snd_hang = 1'b0; Rst_n = 1'b0;
    step(1);
    check("t4_err_cleared", 32'(timeout_err), 0);
    Rst_n = 1'b1;
    step(1);

    // Fill FIFO, push-through on pop, then flush.
    pt_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pt_data = 16'h0100 + 16'(i);
      step(1);
    end
    check("t5_ready_full", 32'(pt_ready), 0);
    check("t5_level_full", 32'(fifo_level), 16);
    pt_data = 16'hBEEF;
    step(5);
    check("t5_level_hold", 32'(fifo_level), 16);
    enable = 1'b1; base = start_data.size();
    wait_starts(base + 1, 600, "t5_start");
    check("t5_head", 32'(start_data[base]), 32'h0100);
    check("t5_level_pushpop", 32'(fifo_level), 16);
    check("t5_ready_again", 32'(pt_ready), 0);
    pt_valid = 1'b0; enable = 1'b0;
    wait_idle(600, "t5_idle");
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("t5_flush_level", 32'(fifo_level), 0);
    check("t5_flush_ready", 32'(pt_ready), 1);

    // 300-clock ticks against a 400-clock sender: every other tick is missed.
    f_enable = 1'b1;
    step(2000);
    check("t3_starts", 32'(f_starts), 3);
    check("t3_overrun", 32'(f_overrun), 3);
    check("t3_underrun", 32'(f_underrun), 3);
    check("t3_start_spacing", 32'(f_last - f_prev), 600);
    check("t3_start_busy", 32'(f_bad), 0);
    f_enable = 1'b0;

    check("start_while_busy", 32'(bad_start), 0);
    check("start_width", 32'(dbl_start), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
